imem_loader: RTL

Writer side of the instruction memory: receives a program image as a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them sequentially into a writable instruction memory starting at word address 0. It holds the pipeline CPU in reset (`cpu_hold`) until a complete image with a correct checksum has been written. It sits between the host byte link (UART receiver or testbench) and the instruction memory write port.

---
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a program image as a byte stream and writes it into
// the instruction memory. The CPU is held in reset until the image is
// complete and its checksum matches.
// Stream: count hi, count lo (N), N words (hi byte first), checksum byte.
// The checksum is the mod-256 sum of the 2N word bytes.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   start         begins a load (honoured in IDLE, DONE, ERR)
//   rx_valid/rx_data/rx_ready   byte-stream handshake
//   imem_we/imem_addr/imem_wdata  instruction memory write port
//   cpu_hold      1 = CPU held in reset
//   done / error  load verified / load aborted
module imem_loader #(
   parameter int unsigned DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [15:0] imem_addr,
   output logic [15:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   localparam int unsigned CW = 16;
   localparam int unsigned BW = 8;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_CHECK, S_DONE, S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   cnt_hi_q, cnt_hi_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [BW-1:0]   hi_q, hi_d;
   logic [BW-1:0]   sum_q, sum_d;
   logic            rx_ready_q, rx_ready_d;
   logic            we_q, we_d;
   logic [CW-1:0]   addr_q, addr_d;
   logic [CW-1:0]   wdata_q, wdata_d;
   logic            hold_q, hold_d;
   logic            done_q, done_d;
   logic            error_q, error_d;

   logic            accept;
   logic [CW-1:0]   cnt_rx;

   assign accept = rx_valid && rx_ready_q;
   assign cnt_rx = {cnt_hi_q, rx_data};

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_hi_q   <= '0;
         count_q    <= '0;
         idx_q      <= '0;
         hi_q       <= '0;
         sum_q      <= '0;
         rx_ready_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_hi_q   <= cnt_hi_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         hi_q       <= hi_d;
         sum_q      <= sum_d;
         rx_ready_q <= rx_ready_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      cnt_hi_d = cnt_hi_q;
      count_d  = count_q;
      idx_d    = idx_q;
      hi_d     = hi_q;
      sum_d    = sum_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      hold_d   = hold_q;
      done_d   = done_q;
      error_d  = error_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_CNT_HI;
               idx_d   = '0;
               sum_d   = '0;
               done_d  = 1'b0;
               error_d = 1'b0;
               hold_d  = 1'b1;
            end
         end
         S_CNT_HI: begin
            if (accept) begin
               cnt_hi_d = rx_data;
               state_d  = S_CNT_LO;
            end
         end
         S_CNT_LO: begin
            if (accept) begin
               count_d = cnt_rx;
               if ({1'b0, cnt_rx} > DEPTH_W) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end else if (cnt_rx == '0) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DAT_HI;
               end
            end
         end
         S_DAT_HI: begin
            if (accept) begin
               hi_d    = rx_data;
               sum_d   = sum_q + rx_data;
               state_d = S_DAT_LO;
            end
         end
         S_DAT_LO: begin
            if (accept) begin
               sum_d   = sum_q + rx_data;
               we_d    = 1'b1;
               addr_d  = idx_q;
               wdata_d = {hi_q, rx_data};
               idx_d   = idx_q + CW'(1);
               // count_q >= 1 here, so count_q - 1 cannot wrap
               state_d = (idx_q == count_q - CW'(1)) ? S_CHECK : S_DAT_HI;
            end
         end
         S_CHECK: begin
            if (accept) begin
               if (rx_data == sum_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Registered ready tracks the state being entered
      rx_ready_d = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) ||
                   (state_d == S_DAT_HI) || (state_d == S_DAT_LO) ||
                   (state_d == S_CHECK);
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule
